// File: rtl/pipe_pkg.sv
// Shared decode-stage definitions: forwarding mux encodings and default widths.
package pipe_pkg;

  // Per-port operand source select.
  localparam logic [1:0] FWD_BANK = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_DM   = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b11;

  // Default register/datapath width and register address width.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_fwd_bank_if.sv
// Decode-stage register bank bus: read ports, forwarding inputs, write port,
// issue tracking and hazard outputs.
interface regfile_fwd_bank_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2
);
  logic [NRD-1:0]          rd_en;
  logic [NRD*ADDR_W-1:0]   rd_addr;
  logic [NRD*2-1:0]        fwd_sel;
  logic [DATA_W-1:0]       fwd_ex;
  logic [DATA_W-1:0]       fwd_dm;
  logic [DATA_W-1:0]       fwd_wb;
  logic [DATA_W-1:0]       imm;
  logic                    imm_sel;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    issue_en;
  logic [ADDR_W-1:0]       iss_addr;
  logic [NRD*DATA_W-1:0]   rd_data;
  logic                    stall;
  logic [(1<<ADDR_W)-1:0]  pending;

  // Pipeline side: drives requests, observes operands and hazards.
  modport master (
    output rd_en, rd_addr, fwd_sel, fwd_ex, fwd_dm, fwd_wb, imm, imm_sel,
           wr_en, wr_addr, wr_data, issue_en, iss_addr,
    input  rd_data, stall, pending
  );

  // Register bank side.
  modport slave (
    input  rd_en, rd_addr, fwd_sel, fwd_ex, fwd_dm, fwd_wb, imm, imm_sel,
           wr_en, wr_addr, wr_data, issue_en, iss_addr,
    output rd_data, stall, pending
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: tracks registers owed a result by an in-flight
// instruction and flags read-after-write hazards on the read ports.
module regfile_scoreboard
  import pipe_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic                   i_issue_en,
  input  logic [ADDR_W-1:0]      i_iss_addr,
  input  logic [NRD-1:0]         i_rd_en,
  input  logic [NRD*ADDR_W-1:0]  i_rd_addr,
  output logic [(1<<ADDR_W)-1:0] o_pending,
  output logic                   o_stall
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_nxt;
  logic             w_stall;
  logic             w_iss_ok;

  assign w_iss_ok = i_issue_en && !((ZERO_REG != 0) && (i_iss_addr == '0));

  // Next scoreboard state: retire on write, then mark on issue so the newer owner wins.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps partial updates from inferring latches.
    w_pending_nxt = r_pending;
    if (i_wr_en)  w_pending_nxt[i_wr_addr]  = 1'b0;
    if (w_iss_ok) w_pending_nxt[i_iss_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  // Hazard: an enabled read of a pending register not satisfied by a same-cycle write.
  always_comb begin
    logic [ADDR_W-1:0] v_addr;
    w_stall = 1'b0;
    v_addr  = '0;
    for (int p = 0; p < NRD; p++) begin
      v_addr = i_rd_addr[p*ADDR_W +: ADDR_W];
      if (i_rd_en[p] && r_pending[v_addr] && !(i_wr_en && (i_wr_addr == v_addr)))
        w_stall = 1'b1;
    end
  end

  assign o_pending = r_pending;
  assign o_stall   = w_stall;
endmodule

// File: rtl/regfile_fwd_bank.sv
// Decode-stage register bank with registered read ports, write-through bypass,
// per-port forwarding muxes, immediate override and a RAW-hazard scoreboard.
module regfile_fwd_bank
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input logic              clk,
  input logic              rst_n,
  regfile_fwd_bank_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_bank [DEPTH];
  logic              w_wr_ok;

  // Writes to the hardwired zero register are dropped.
  assign w_wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // Register bank storage with full clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this bank is reset entry by entry, so it maps to flops rather than RAM; state uses <= only.
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else if (w_wr_ok) begin
      r_bank[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_sel;
    logic [DATA_W-1:0] r_rdq;
    logic [DATA_W-1:0] w_out;

    assign w_addr = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign w_sel  = bus.fwd_sel[p*2 +: 2];

    // Registered read with zero-register and same-edge write bypass.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rdq <= '0;
      end else if (bus.rd_en[p]) begin
        if ((ZERO_REG != 0) && (w_addr == '0))  r_rdq <= '0;
        else if (w_wr_ok && (bus.wr_addr == w_addr)) r_rdq <= bus.wr_data;
        else                                      r_rdq <= r_bank[w_addr];
      end
    end

    // Operand select: bank, forwarded results, or immediate on the last port.
    always_comb begin
      w_out = r_rdq;
      case (w_sel)
        FWD_EX:  w_out = bus.fwd_ex;
        FWD_DM:  w_out = bus.fwd_dm;
        FWD_WB:  w_out = bus.fwd_wb;
        default: w_out = r_rdq;
      endcase
      if ((p == NRD-1) && bus.imm_sel) w_out = bus.imm;
    end

    assign bus.rd_data[p*DATA_W +: DATA_W] = w_out;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_issue_en (bus.issue_en),
    .i_iss_addr (bus.iss_addr),
    .i_rd_en    (bus.rd_en),
    .i_rd_addr  (bus.rd_addr),
    .o_pending  (bus.pending),
    .o_stall    (bus.stall)
  );
endmodule

// File: tb/tb_regfile_fwd_bank.sv
// Bench for regfile_fwd_bank: directed vector table, async-reset hazard
// sequence, then random traffic against an array-based reference model.
module tb_regfile_fwd_bank;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NP = 2;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_fwd_bank_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NP)) bus ();

  regfile_fwd_bank #(.DATA_W(DW), .ADDR_W(AW), .NRD(NP), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rd_en;
    logic [4:0]  a0, a1;
    logic [1:0]  s0, s1;
    logic        wr_en;
    logic [4:0]  wa;
    logic [7:0]  wd;
    logic        iss;
    logic [4:0]  ia;
    logic        imm_sel;
    logic [7:0]  fx, fd, fw, imm;
    logic        exp_stall;
    logic [7:0]  exp_d0, exp_d1;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t tbl [16];

  // Reference model state.
  logic [7:0]  m_bank [32];
  logic [7:0]  m_rdq  [NP];
  logic [31:0] m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] rd_en, input int a0, input int a1,
                              input int s0, input int s1, input logic wr_en, input int wa,
                              input int wd, input logic iss, input int ia, input logic imm_sel,
                              input logic exp_stall, input int exp_d0, input int exp_d1,
                              input logic [31:0] exp_pend);
    vec_t v;
    v.rd_en = rd_en; v.a0 = 5'(a0); v.a1 = 5'(a1); v.s0 = 2'(s0); v.s1 = 2'(s1);
    v.wr_en = wr_en; v.wa = 5'(wa); v.wd = 8'(wd); v.iss = iss; v.ia = 5'(ia);
    v.imm_sel = imm_sel; v.fx = 8'h11; v.fd = 8'h22; v.fw = 8'h33; v.imm = 8'h5A;
    v.exp_stall = exp_stall; v.exp_d0 = 8'(exp_d0); v.exp_d1 = 8'(exp_d1);
    v.exp_pend = exp_pend;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.rd_en    = v.rd_en;
    bus.rd_addr  = {v.a1, v.a0};
    bus.fwd_sel  = {v.s1, v.s0};
    bus.wr_en    = v.wr_en;
    bus.wr_addr  = v.wa;
    bus.wr_data  = v.wd;
    bus.issue_en = v.iss;
    bus.iss_addr = v.ia;
    bus.imm_sel  = v.imm_sel;
    bus.fwd_ex   = v.fx;
    bus.fwd_dm   = v.fd;
    bus.fwd_wb   = v.fw;
    bus.imm      = v.imm;
  endtask

  function automatic vec_t idle();
    return mk(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 32'h0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_bank[i] = '0;
    for (int p = 0; p < NP; p++) m_rdq[p] = '0;
    m_pend = '0;
  endtask

  function automatic logic [7:0] model_out(input vec_t v, input int p);
    logic [1:0] sel;
    sel = (p == 0) ? v.s0 : v.s1;
    if (p == NP-1 && v.imm_sel) return v.imm;
    if (sel == 2'd1) return v.fx;
    if (sel == 2'd2) return v.fd;
    if (sel == 2'd3) return v.fw;
    return m_rdq[p];
  endfunction

  function automatic logic model_stall(input vec_t v);
    logic [4:0] a;
    logic       s;
    s = 1'b0;
    for (int p = 0; p < NP; p++) begin
      a = (p == 0) ? v.a0 : v.a1;
      if (v.rd_en[p] && m_pend[a] && !(v.wr_en && v.wa == a)) s = 1'b1;
    end
    return s;
  endfunction

  // Apply one rising edge to the model: reads see the old bank or the same-edge write.
  task automatic model_edge(input vec_t v);
    logic [4:0] a;
    for (int p = 0; p < NP; p++) begin
      a = (p == 0) ? v.a0 : v.a1;
      if (v.rd_en[p]) begin
        if (a == 0)                    m_rdq[p] = 8'h00;
        else if (v.wr_en && v.wa == a) m_rdq[p] = v.wd;
        else                           m_rdq[p] = m_bank[a];
      end
    end
    if (v.wr_en && v.wa != 0) m_bank[v.wa] = v.wd;
    if (v.wr_en) m_pend[v.wa] = 1'b0;
    if (v.iss && v.ia != 0) m_pend[v.ia] = 1'b1;
  endtask

  initial begin
    vec_t v;

    tbl[0]  = mk(2'b01, 3, 0, 0, 0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
    tbl[1]  = mk(2'b00, 0, 0, 0, 0, 1'b1, 5, 8'hA7, 1'b0, 0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
    tbl[2]  = mk(2'b01, 5, 0, 0, 0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'hA7, 8'h00, 32'h0);
    tbl[3]  = mk(2'b10, 5, 7, 0, 0, 1'b1, 7, 8'h3C, 1'b0, 0, 1'b0, 1'b0, 8'hA7, 8'h3C, 32'h0);
    tbl[4]  = mk(2'b01, 0, 7, 0, 0, 1'b1, 0, 8'hFF, 1'b0, 0, 1'b0, 1'b0, 8'h00, 8'h3C, 32'h0);
    tbl[5]  = mk(2'b01, 0, 7, 0, 0, 1'b0, 0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h00, 8'h3C, 32'h0);
    tbl[6]  = mk(2'b00, 0, 7, 0, 0, 1'b0, 0, 8'h00, 1'b1, 9, 1'b0, 1'b0, 8'h00, 8'h3C, 32'h200);
    tbl[7]  = mk(2'b01, 9, 7, 0, 0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'h00, 8'h3C, 32'h200);
    tbl[8]  = mk(2'b01, 9, 7, 0, 0, 1'b1, 9, 8'h5E, 1'b0, 0, 1'b0, 1'b0, 8'h5E, 8'h3C, 32'h0);
    tbl[9]  = mk(2'b00, 9, 7, 0, 0, 1'b1, 4, 8'h44, 1'b1, 4, 1'b0, 1'b0, 8'h5E, 8'h3C, 32'h10);
    tbl[10] = mk(2'b10, 9, 4, 0, 0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'h5E, 8'h44, 32'h10);
    tbl[11] = mk(2'b00, 9, 4, 0, 1, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h5E, 8'h11, 32'h10);
    tbl[12] = mk(2'b00, 9, 4, 0, 2, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h5E, 8'h22, 32'h10);
    tbl[13] = mk(2'b00, 9, 4, 0, 3, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h5E, 8'h33, 32'h10);
    tbl[14] = mk(2'b00, 9, 4, 0, 0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h5E, 8'h5A, 32'h10);
    tbl[15] = mk(2'b00, 9, 4, 3, 0, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h33, 8'h44, 32'h10);

    // Reset, released between clock edges.
    rst_n = 1'b0;
    drive(idle());
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_stall",   32'(bus.stall),   32'h0);
    check("reset_pending", bus.pending,      32'h0);
    check("reset_rd_data", 32'(bus.rd_data), 32'h0);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("tbl%0d_stall", i), 32'(bus.stall), 32'(tbl[i].exp_stall));
      @(posedge clk); #1;
      check($sformatf("tbl%0d_d0", i),   32'(bus.rd_data[7:0]),  32'(tbl[i].exp_d0));
      check($sformatf("tbl%0d_d1", i),   32'(bus.rd_data[15:8]), 32'(tbl[i].exp_d1));
      check($sformatf("tbl%0d_pend", i), bus.pending,            tbl[i].exp_pend);
    end

    // Async reset while a hazard is active; r4 is still pending from the table.
    drive(mk(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 1'b1, 9, 1'b0, 1'b0, 0, 0, 32'h0));
    @(posedge clk); #1;
    drive(mk(2'b01, 9, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 32'h0));
    #1;
    check("hz_stall_before", 32'(bus.stall), 32'h1);
    check("hz_pend_before",  bus.pending,    32'h210);
    rst_n = 1'b0;
    #1;
    check("hz_stall_async", 32'(bus.stall),          32'h0);
    check("hz_pend_async",  bus.pending,             32'h0);
    check("hz_rd_async",    32'(bus.rd_data[7:0]),   32'h0);
    drive(idle());
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // Random traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      v = idle();
      v.rd_en   = 2'($urandom_range(0, 3));
      v.a0      = 5'($urandom_range(0, 7));
      v.a1      = 5'($urandom_range(0, 7));
      v.s0      = 2'($urandom_range(0, 3));
      v.s1      = 2'($urandom_range(0, 3));
      v.wr_en   = ($urandom_range(0, 1) == 1);
      v.wa      = 5'($urandom_range(0, 7));
      v.wd      = 8'($urandom);
      v.iss     = ($urandom_range(0, 2) == 0);
      v.ia      = 5'($urandom_range(0, 7));
      v.imm_sel = ($urandom_range(0, 3) == 0);
      v.fx      = 8'($urandom);
      v.fd      = 8'($urandom);
      v.fw      = 8'($urandom);
      v.imm     = 8'($urandom);
      drive(v);
      #1;
      check($sformatf("rnd%0d_stall", n), 32'(bus.stall),          32'(model_stall(v)));
      check($sformatf("rnd%0d_d0", n),    32'(bus.rd_data[7:0]),   32'(model_out(v, 0)));
      check($sformatf("rnd%0d_d1", n),    32'(bus.rd_data[15:8]),  32'(model_out(v, 1)));
      check($sformatf("rnd%0d_pend", n),  bus.pending,             m_pend);
      model_edge(v);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
